// File: rtl/mem_access_unit_pkg.sv
// Shared op codes, FSM encodings and decode helpers for the MEM-stage load/store front-end.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    // Bit-per-opcode masks, indexed by op_t.
    localparam logic [7:0] IS_STORE   = 8'b1110_0000;
    localparam logic [7:0] IS_SUBWORD = 8'b0110_1111;

    function automatic logic misaligned(input op_t op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return off != 2'b00;
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and DataMemory-side bus of the load/store front-end.
interface mem_access_unit_if #(parameter int ADDR_W = 10);
    logic              Req;
    logic              Ready;
    logic [2:0]        Op;
    logic [ADDR_W+1:0] ByteAddr;
    logic [31:0]       StoreData;
    logic [31:0]       LoadData;
    logic              LoadValid;
    logic              Misalign;
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [31:0]       MemReadData;

    modport master (
        input  Req, Op, ByteAddr, StoreData, MemReadData,
        output Ready, LoadData, LoadValid, Misalign,
               MemAddress, MemWriteData, MemWrite, MemRead
    );

    modport slave (
        output Req, Op, ByteAddr, StoreData, MemReadData,
        input  Ready, LoadData, LoadValid, Misalign,
               MemAddress, MemWriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Byte-lane datapath: extract/extend for loads, lane replacement for sb/sh read-modify-write.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  op_t         op,
    input  logic [1:0]  off,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] wr_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_word[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (op)
            OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data = {24'd0, byte_sel};
            OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_data = {16'd0, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] LANE = 2'(k);
        logic       hit;
        logic [7:0] src;

        // sh writes its low byte to the even lane and its high byte to the odd lane.
        assign hit = (op == OP_SB) ? (off == LANE)
                                   : ((op == OP_SH) && (off[1] == LANE[1]));
        assign src = ((op == OP_SH) && LANE[0]) ? st_data[15:8] : st_data[7:0];
        assign wr_word[8*k +: 8] = hit ? src : rd_word[8*k +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: byte-addressed MIPS accesses onto word-addressed DataMemory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               Clk,
    input  logic               Rst_n,
    mem_access_unit_if.master  bus
);

    state_t            state_q, state_d;
    op_t               op_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       st_q;
    logic              lv_q, lv_d;
    logic              mis_q, mis_d;
    logic              cap;

    op_t               op_in;
    logic [1:0]        off_in;
    logic [ADDR_W-1:0] word_in;
    logic              acc;
    logic [31:0]       ld_data, wr_word;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wr, mem_rd;

    assign op_in   = op_t'(bus.Op);
    assign off_in  = bus.ByteAddr[1:0];
    assign word_in = bus.ByteAddr[ADDR_W+1:2];
    // Gating with Rst_n keeps memory strobes low for the whole reset window.
    assign acc     = bus.Req && (state_q == ST_IDLE) && Rst_n;

    mem_byte_lane u_lane (
        .rd_word (bus.MemReadData),
        .op      (op_q),
        .off     (off_q),
        .st_data (st_q),
        .ld_data (ld_data),
        .wr_word (wr_word)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LB;
            off_q   <= '0;
            addr_q  <= '0;
            st_q    <= '0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
            if (cap) begin
                op_q   <= op_in;
                off_q  <= off_in;
                addr_q <= word_in;
                st_q   <= bus.StoreData[15:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        cap       = 1'b0;
        lv_d      = 1'b0;
        mis_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (misaligned(op_in, off_in)) begin
                        mis_d = 1'b1;
                    end else begin
                        mem_addr = word_in;
                        if (!IS_STORE[op_in]) begin
                            mem_rd = 1'b1;
                            lv_d   = 1'b1;
                            cap    = 1'b1;
                        end else if (!IS_SUBWORD[op_in]) begin
                            mem_wr    = 1'b1;
                            mem_wdata = bus.StoreData;
                        end else begin
                            mem_rd  = 1'b1;
                            cap     = 1'b1;
                            state_d = ST_RMW_WR;
                        end
                    end
                end
            end
            ST_RMW_WR: begin
                // Request inputs are ignored here; the old word arrives on MemReadData.
                mem_addr  = addr_q;
                mem_wdata = wr_word;
                mem_wr    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Ready        = (state_q == ST_IDLE);
    assign bus.LoadValid    = lv_q;
    assign bus.Misalign     = mis_q;
    assign bus.LoadData     = ld_data;
    assign bus.MemAddress   = mem_addr;
    assign bus.MemWriteData = mem_wdata;
    assign bus.MemWrite     = mem_wr;
    assign bus.MemRead      = mem_rd;

endmodule
